cpu_bus_bridge: RTL
===================

Name: cpu_bus_bridge

Overview:
- Bus slave directly downstream of the CPU core's memory port.
- Accepts the CPU's four-phase request (bus_clk / we / addr / data) and decodes the address into one of three regions: internal block RAM with programmable wait states, an external peripheral port with req/ack handshake and timeout, or unmapped.
- Returns read data and the bus_data_ready acknowledge that the CPU sequencer waits on.

Parameters:
- DATA_W, 32, data bus width in bits; matches the CPU VW width.
- ADDR_W, 32, address bus width in bits; addresses are word addresses.
- RAM_AW, 14, RAM depth is 2^RAM_AW words; RAM region is addr[ADDR_W-1:RAM_AW]==0.
- RAM_WAIT, 1, wait cycles inserted before a RAM access, range 0..15.
- PER_BASE, 32'h0001_0000, base word address of the peripheral window.
- PER_AW, 8, peripheral window size is 2^PER_AW words.
- PER_TIMEOUT, 64, cycles allowed for i_per_ack before the bridge aborts; must be ≥2.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a peripheral timeout.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_bus_clk  input  1  CPU request strobe; held high until ready is seen.
- i_bus_we  input  1  1 = write, 0 = read; valid while i_bus_clk=1.
- i_bus_addr  input  ADDR_W  word address.
- i_bus_data  input  DATA_W  write data.
- o_bus_data  output  DATA_W  read data; valid while o_bus_data_ready=1.
- o_bus_data_ready  output  1  acknowledge to the CPU.
- o_bus_err  output  1  error flag, qualified by o_bus_data_ready.
- o_per_req  output  1  peripheral request, level.
- o_per_we  output  1  peripheral write enable.
- o_per_addr  output  PER_AW  peripheral word offset.
- o_per_wdata  output  DATA_W  peripheral write data.
- i_per_ack  input  1  peripheral completion, single-cycle pulse.
- i_per_rdata  input  DATA_W  peripheral read data, valid with i_per_ack.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - All outputs 0.
  - State forced to IDLE; wait and timeout counters cleared.
  - RAM contents are not cleared.
  - Reset mid-transaction abandons it with no RAM write, and o_per_req drops immediately.
- IDLE:
  - On a cycle with i_bus_clk=1, latch addr/we/data and decode.
  - RAM hit: go to RAM_WAIT with counter=RAM_WAIT; if RAM_WAIT=0, go straight to RAM_ACC.
  - Peripheral hit: go to PER; drive o_per_req=1 and o_per_we/addr/wdata from latched values.
  - Unmapped: go to DONE with o_bus_data=0, o_bus_err=1.
- RAM_WAIT: decrement the counter each cycle; at 1, go to RAM_ACC.
- RAM_ACC (one cycle):
  - Synchronous RAM read or write at addr[RAM_AW-1:0].
  - Next state DONE: read data registered into o_bus_data; on a write, o_bus_data=0. o_bus_err=0.
- RAM latency:
  - Request seen in cycle N; o_bus_data_ready rises at edge N+2+RAM_WAIT.
  - Example: RAM_WAIT=1 gives ready 3 cycles after the request is sampled.
- PER:
  - o_per_req held high; a timeout counter increments each cycle.
  - i_per_ack=1: capture i_per_rdata (read) or 0 (write); drop o_per_req next edge; go to DONE with err=0.
  - Counter reaches PER_TIMEOUT with no ack: drop o_per_req; go to DONE with o_bus_data=ERR_DATA, err=1.
  - An ack arriving in the same cycle as the timeout wins (counts as success).
  - Acks arriving while not in PER are ignored.
- DONE:
  - o_bus_data_ready=1; data and err are held stable.
  - Remain in DONE until i_bus_clk=0, then ready=0 next edge and return to IDLE.
  - A new request is not accepted until ready has been low for one cycle, because IDLE samples i_bus_clk only after DONE exits.
- Request rules:
  - i_bus_clk falling before ready (protocol violation): the transaction still completes, ready pulses for one cycle, then IDLE.
  - Address/data changes after latching are ignored.
- Address boundaries:
  - RAM top word (2^RAM_AW-1) maps to RAM; 2^RAM_AW is unmapped unless PER_BASE equals it.
  - Peripheral window is PER_BASE ≤ addr < PER_BASE+2^PER_AW; o_per_addr = addr-PER_BASE, truncated to PER_AW bits.
  - RAM decode takes priority if the two regions overlap.
- Throughput: one transaction in flight; no pipelining.

Test Plan:
- RAM write/read, RAM_WAIT=1: write 32'h1234_5678 to addr 0x0010, then read 0x0010 → ready 3 cycles after each request, o_bus_data=32'h1234_5678, err=0; ready drops one cycle after i_bus_clk falls.
- RAM boundary: write/read addr 0x3FFF → round-trips correctly; read 0x4000 → ready next+1 cycle, data=0, err=1, o_per_req never asserts.
- Peripheral read: read 0x0001_0005, peripheral acks after 5 cycles with 32'hCAFE_0001 → o_per_addr=8'h05, o_per_we=0, o_bus_data=32'hCAFE_0001, err=0; o_per_req low the cycle after ack.
- Peripheral timeout: write to 0x0001_00FF with no ack → o_per_req high exactly 64 cycles, then ready=1, err=1, o_bus_data=32'hDEAD_BEEF; a late ack is ignored.
- Ack/timeout collision: ack in the 64th cycle with 32'h0000_00AA → err=0, data=32'h0000_00AA.
- Reset mid-operation: assert i_rst_n=0 during RAM_WAIT of a write to 0x0020 holding 32'h1111_1111 → ready/req clear asynchronously; after release, reading 0x0020 returns 32'h1111_1111 (write suppressed).

Source files
------------

// File: rtl/cpu_bus_bridge.sv
// Bus slave behind the CPU memory port. Each request goes to one of three places:
// internal block RAM with wait states, a req/ack peripheral port with a timeout, or an error response.
module cpu_bus_bridge #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                RAM_AW      = 14,
  parameter int                RAM_WAIT    = 1,
  parameter logic [ADDR_W-1:0] PER_BASE    = 32'h0001_0000,
  parameter int                PER_AW      = 8,
  parameter int                PER_TIMEOUT = 64,
  parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bus_clk,
  input  logic              i_bus_we,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic [DATA_W-1:0] i_bus_data,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_data_ready,
  output logic              o_bus_err,
  output logic              o_per_req,
  output logic              o_per_we,
  output logic [PER_AW-1:0] o_per_addr,
  output logic [DATA_W-1:0] o_per_wdata,
  input  logic              i_per_ack,
  input  logic [DATA_W-1:0] i_per_rdata
);

  localparam int                TCNT_W    = (PER_TIMEOUT > 2) ? $clog2(PER_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TMO_LAST  = TCNT_W'(PER_TIMEOUT - 1);
  localparam logic [3:0]        WAIT_INIT = 4'(RAM_WAIT);
  localparam logic [ADDR_W:0]   PER_LIMIT = {1'b0, PER_BASE} + ((ADDR_W+1)'(1) << PER_AW);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAM_WAIT = 3'd1,
    S_RAM_ACC  = 3'd2,
    S_RESP     = 3'd3,
    S_PER      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  function automatic logic is_ram(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:RAM_AW] == '0;
  endfunction

  function automatic logic is_per(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= {1'b0, PER_BASE}) && ({1'b0, a} < PER_LIMIT);
  endfunction

  function automatic logic [PER_AW-1:0] per_off(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] d;
    d = a - PER_BASE;
    return d[PER_AW-1:0];
  endfunction

  state_t              state_r;
  logic [3:0]          wait_cnt_r;
  logic [TCNT_W-1:0]   tmo_cnt_r;
  logic [RAM_AW-1:0]   ram_idx_r;
  logic                we_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                unmapped_r;
  logic [DATA_W-1:0]   ram_q_r;
  logic [DATA_W-1:0]   mem_r [0:(1<<RAM_AW)-1];

  logic                ram_hit_s;
  logic                per_hit_s;
  logic [PER_AW-1:0]   per_off_s;

  assign ram_hit_s = is_ram(i_bus_addr);
  assign per_hit_s = is_per(i_bus_addr);
  assign per_off_s = per_off(i_bus_addr);

  // Block RAM: a single access port, used only in RAM_ACC, so an aborted request never writes
  always_ff @(posedge i_clk) begin
    if (state_r == S_RAM_ACC) begin
      if (we_r) begin
        mem_r[ram_idx_r] <= wdata_r;
      end
      ram_q_r <= mem_r[ram_idx_r];
    end
  end

  // Transaction sequencer; every bus and peripheral output is registered here
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r          <= S_IDLE;
      wait_cnt_r       <= 4'd0;
      tmo_cnt_r        <= '0;
      ram_idx_r        <= '0;
      we_r             <= 1'b0;
      wdata_r          <= '0;
      unmapped_r       <= 1'b0;
      o_bus_data       <= '0;
      o_bus_data_ready <= 1'b0;
      o_bus_err        <= 1'b0;
      o_per_req        <= 1'b0;
      o_per_we         <= 1'b0;
      o_per_addr       <= '0;
      o_per_wdata      <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_bus_clk) begin
            ram_idx_r <= i_bus_addr[RAM_AW-1:0];
            we_r      <= i_bus_we;
            wdata_r   <= i_bus_data;
            if (ram_hit_s) begin
              unmapped_r <= 1'b0;
              if (RAM_WAIT == 0) begin
                state_r <= S_RAM_ACC;
              end else begin
                wait_cnt_r <= WAIT_INIT;
                state_r    <= S_RAM_WAIT;
              end
            end else if (per_hit_s) begin
              unmapped_r  <= 1'b0;
              tmo_cnt_r   <= '0;
              o_per_req   <= 1'b1;
              o_per_we    <= i_bus_we;
              o_per_addr  <= per_off_s;
              o_per_wdata <= i_bus_data;
              state_r     <= S_PER;
            end else begin
              unmapped_r <= 1'b1;
              state_r    <= S_RESP;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RAM_WAIT: begin
          wait_cnt_r <= wait_cnt_r - 4'd1;
          if (wait_cnt_r == 4'd1) begin
            state_r <= S_RAM_ACC;
          end else begin
            state_r <= S_RAM_WAIT;
          end
        end
        S_RAM_ACC: begin
          state_r <= S_RESP;
        end
        // RAM read data becomes visible one cycle after the access; unmapped requests share this slot
        S_RESP: begin
          o_bus_data       <= (unmapped_r || we_r) ? '0 : ram_q_r;
          o_bus_err        <= unmapped_r;
          o_bus_data_ready <= 1'b1;
          state_r          <= S_DONE;
        end
        S_PER: begin
          if (i_per_ack) begin
            o_bus_data       <= o_per_we ? '0 : i_per_rdata;
            o_bus_err        <= 1'b0;
            o_bus_data_ready <= 1'b1;
            o_per_req        <= 1'b0;
            o_per_we         <= 1'b0;
            o_per_addr       <= '0;
            o_per_wdata      <= '0;
            state_r          <= S_DONE;
          end else if (tmo_cnt_r == TMO_LAST) begin
            o_bus_data       <= ERR_DATA;
            o_bus_err        <= 1'b1;
            o_bus_data_ready <= 1'b1;
            o_per_req        <= 1'b0;
            o_per_we         <= 1'b0;
            o_per_addr       <= '0;
            o_per_wdata      <= '0;
            state_r          <= S_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TCNT_W'(1);
            state_r   <= S_PER;
          end
        end
        S_DONE: begin
          if (!i_bus_clk) begin
            o_bus_data_ready <= 1'b0;
            o_bus_data       <= '0;
            o_bus_err        <= 1'b0;
            state_r          <= S_IDLE;
          end else begin
            state_r <= S_DONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
